// File: rtl/cpu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_definitions / fetch_definitions (packages)
// Description : PC-source encoding and fetch slot record shared by the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================

package pc_definitions;
    typedef enum logic [1:0] {
        PC_INC = 2'b00,
        PC_BR  = 2'b01,
        PC_JAL = 2'b10
    } pc_source_t;
endpackage

package fetch_definitions;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_slot_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

`default_nettype wire

// File: rtl/cpu_fetch_slot_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_slot_buffer
// Description : Circular in-order buffer of fetch slots; allocate on request,
//               fill on response, pop on decode handshake, flush on redirect.
// Revision    : 1.0 - initial release
// ============================================================================

module fetch_slot_buffer
    import fetch_definitions::*;
#(
    parameter int  DEPTH   = 2,
    localparam int c_cnt_w = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_alloc,
    input  logic [31:0]        i_alloc_pc,
    input  logic               i_fill,
    input  logic [31:0]        i_fill_data,
    input  logic               i_pop,
    output fetch_slot_t        o_head,
    output logic               o_free,
    output logic [c_cnt_w-1:0] o_unfilled
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_slot_t        r_slots [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_ptr_w-1:0] r_fill_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] r_unfilled;
    logic               w_bypass;
    fetch_slot_t        w_head_slot;

    // A response landing in the empty head slot is forwarded straight to decode.
    assign w_bypass    = i_fill && (r_unfilled != '0) && (r_fill_ptr == r_head);
    assign w_head_slot = r_slots[r_head];

    always_comb begin
        o_head        = w_head_slot;
        o_head.instr  = w_head_slot.filled ? w_head_slot.instr : i_fill_data;
        o_head.filled = (r_count != '0) && (w_head_slot.filled || w_bypass);
    end

    assign o_free     = (r_count < c_cnt_w'(DEPTH));
    assign o_unfilled = r_unfilled;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_fill_ptr <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i].filled <= 1'b0;
            end
        end else begin
            if (i_alloc) begin
                r_slots[r_tail].pc     <= i_alloc_pc;
                r_slots[r_tail].filled <= 1'b0;
                r_tail                 <= r_tail + 1'b1;
            end
            if (i_fill) begin
                r_slots[r_fill_ptr].instr  <= i_fill_data;
                r_slots[r_fill_ptr].filled <= 1'b1;
                r_fill_ptr                 <= r_fill_ptr + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end

            case ({i_alloc, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            case ({i_alloc, i_fill})
                2'b10:   r_unfilled <= r_unfilled + 1'b1;
                2'b01:   r_unfilled <= r_unfilled - 1'b1;
                default: r_unfilled <= r_unfilled;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : cpu_fetch
// Description : Instruction-fetch stage: PC, imem request issue, in-order
//               response buffering, redirect handling and wrong-path squash.
// Revision    : 1.0 - initial release
// ============================================================================

module cpu_fetch
    import pc_definitions::*;
    import fetch_definitions::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_src,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam int c_drop_w = $clog2(2 * DEPTH + 1);

    logic [31:0]         r_pc;
    logic [c_drop_w-1:0] r_drop_cnt;

    logic                w_redirect;
    logic                w_alloc;
    logic                w_fill;
    logic                w_drop;
    logic                w_pop;
    logic                w_free;
    logic [c_cnt_w-1:0]  w_unfilled;
    logic [c_drop_w-1:0] w_unfilled_ext;
    logic [c_drop_w-1:0] w_resp_ext;
    fetch_slot_t         w_head;

    assign w_redirect = redirect_valid && (redirect_src != PC_INC);

    assign imem_req_valid = !rst && w_free && !redirect_valid;
    assign imem_req_addr  = r_pc;
    assign w_alloc        = imem_req_valid && imem_req_ready;

    // Responses owed to squashed requests are swallowed before any slot sees them.
    assign w_drop = imem_resp_valid && (r_drop_cnt != '0);
    assign w_fill = imem_resp_valid && (r_drop_cnt == '0) && !w_redirect;

    assign if_valid    = !rst && w_head.filled && !redirect_valid;
    assign w_pop       = if_valid && if_ready;
    assign if_instr    = if_valid ? w_head.instr : NOP_INSTR;
    assign if_pc       = if_valid ? w_head.pc : 32'h0000_0000;
    assign if_pc_plus4 = if_valid ? (w_head.pc + 32'd4) : 32'h0000_0004;

    assign w_unfilled_ext = c_drop_w'(w_unfilled);
    assign w_resp_ext     = c_drop_w'(imem_resp_valid);

    fetch_slot_buffer #(
        .DEPTH (DEPTH)
    ) u_slots (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (w_redirect),
        .i_alloc     (w_alloc),
        .i_alloc_pc  (r_pc),
        .i_fill      (w_fill),
        .i_fill_data (imem_resp_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_free      (w_free),
        .o_unfilled  (w_unfilled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= {redirect_target[31:2], 2'b00};
        end else if (w_alloc) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // A response arriving in the redirect cycle is itself discarded, hence the subtraction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_redirect) begin
            r_drop_cnt <= r_drop_cnt + w_unfilled_ext - w_resp_ext;
        end else if (w_drop) begin
            r_drop_cnt <= r_drop_cnt - 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_resp_expected : assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> ((w_unfilled != '0) || (r_drop_cnt != '0)))
        else $error("cpu_fetch: imem response with no outstanding request");

    a_src_legal : assert property (@(posedge clk) disable iff (rst)
        redirect_valid |-> (redirect_src != 2'b11))
        else $error("cpu_fetch: illegal redirect_src encoding");
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_fetch
// Description : Directed self-checking bench for cpu_fetch with an in-order imem model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_cpu_fetch;
    import pc_definitions::*;
    import fetch_definitions::*;

    localparam logic [31:0] c_xor = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    logic        clk;
    logic        rst, imem_req_valid, imem_req_ready, imem_resp_valid, redirect_valid, if_valid, if_ready;
    logic [31:0] imem_req_addr, imem_resp_data, redirect_target, if_instr, if_pc, if_pc_plus4;
    logic [1:0]  redirect_src;

    logic        b_rst, b_req_valid, b_resp_valid, b_redirect_valid, b_if_valid;
    logic [31:0] b_req_addr, b_resp_data, b_redirect_target, b_if_instr, b_if_pc, b_if_pc_plus4;
    logic [1:0]  b_redirect_src;

    pend_t       pend_a[$];
    pend_t       pend_b[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];

    int          cyc, lat, n_acc, n_checks, n_pass;
    bit          rand_mode;
    logic        s_valid, s_req_valid, s2_valid, s2_req_valid;
    logic [31:0] s_pc, s_instr, s_p4, s_req_addr, s2_pc, s2_instr, s2_p4, s2_req_addr;

    cpu_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_src(redirect_src), .redirect_target(redirect_target),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    cpu_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_hi (
        .clk(clk), .rst(b_rst),
        .imem_req_valid(b_req_valid), .imem_req_ready(1'b1), .imem_req_addr(b_req_addr),
        .imem_resp_valid(b_resp_valid), .imem_resp_data(b_resp_data),
        .redirect_valid(b_redirect_valid), .redirect_src(b_redirect_src), .redirect_target(b_redirect_target),
        .if_valid(b_if_valid), .if_ready(1'b1), .if_instr(b_if_instr), .if_pc(b_if_pc), .if_pc_plus4(b_if_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: present due responses, sample settled outputs at negedge, record traffic.
    task automatic step();
        bit    hold;
        pend_t p;
        hold = rand_mode && ($urandom_range(0, 3) == 0);
        if (!hold && pend_a.size() > 0 && pend_a[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pend_a[0].addr ^ c_xor;
            void'(pend_a.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        if (pend_b.size() > 0 && pend_b[0].due <= cyc) begin
            b_resp_valid = 1'b1;
            b_resp_data  = pend_b[0].addr ^ c_xor;
            void'(pend_b.pop_front());
        end else begin
            b_resp_valid = 1'b0;
            b_resp_data  = 32'h0;
        end
        if (rand_mode) begin
            imem_req_ready = ($urandom_range(0, 1) == 1);
            if_ready       = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        s_valid = if_valid;  s_pc = if_pc;  s_instr = if_instr;  s_p4 = if_pc_plus4;
        s_req_valid = imem_req_valid;  s_req_addr = imem_req_addr;
        s2_valid = b_if_valid;  s2_pc = b_if_pc;  s2_instr = b_if_instr;  s2_p4 = b_if_pc_plus4;
        s2_req_valid = b_req_valid;  s2_req_addr = b_req_addr;
        if (imem_req_valid && imem_req_ready) begin
            p.addr = imem_req_addr;  p.due = cyc + lat;
            pend_a.push_back(p);
            n_acc++;
        end
        if (if_valid && if_ready) begin
            got_pc.push_back(if_pc);
            got_instr.push_back(if_instr);
        end
        if (b_req_valid) begin
            p.addr = b_req_addr;  p.due = cyc + 1;
            pend_b.push_back(p);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;  redirect_valid = 1'b0;  redirect_src = PC_INC;  redirect_target = 32'h0;
        imem_req_ready = 1'b1;  if_ready = 1'b1;  lat = 1;  rand_mode = 1'b0;
        pend_a.delete();
        step();
        step();
        rst = 1'b0;
        got_pc.delete();  got_instr.delete();  n_acc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;  b_rst = 1'b1;  imem_req_ready = 1'b1;  if_ready = 1'b1;
        step();
        step();
        n_checks++; if (s_valid !== 1'b0) $display("FAIL reset_if_valid: got %b expected 0", s_valid); else n_pass++;
        n_checks++; if (s_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", s_req_valid); else n_pass++;
        n_checks++; if (s_instr !== 32'h0000_0013) $display("FAIL reset_if_instr: got %h expected 00000013", s_instr); else n_pass++;
        n_checks++; if (s_pc !== 32'h0) $display("FAIL reset_if_pc: got %h expected 00000000", s_pc); else n_pass++;
        n_checks++; if (s_p4 !== 32'h4) $display("FAIL reset_if_pc_plus4: got %h expected 00000004", s_p4); else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset();
        step();
        n_checks++; if (s_valid !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== 32'h0)
            $display("FAIL stream_first_req: got valid=%b req=%b addr=%h expected 0 1 00000000", s_valid, s_req_valid, s_req_addr);
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            step();
            exp = 32'(k * 4);
            n_checks++; if (s_valid !== 1'b1 || s_pc !== exp)
                $display("FAIL stream_pc[%0d]: got valid=%b pc=%h expected 1 %h", k, s_valid, s_pc, exp);
            else n_pass++;
            n_checks++; if (s_instr !== (exp ^ c_xor))
                $display("FAIL stream_instr[%0d]: got %h expected %h", k, s_instr, exp ^ c_xor);
            else n_pass++;
            n_checks++; if (s_p4 !== exp + 32'd4)
                $display("FAIL stream_pc_plus4[%0d]: got %h expected %h", k, s_p4, exp + 32'd4);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        if_ready = 1'b0;
        for (int k = 0; k < 8; k++) step();
        n_checks++; if (n_acc != 2) $display("FAIL stall_accepts: got %0d expected 2", n_acc); else n_pass++;
        n_checks++; if (s_req_valid !== 1'b0) $display("FAIL stall_req_valid: got %b expected 0", s_req_valid); else n_pass++;
        n_checks++; if (got_pc.size() != 0) $display("FAIL stall_no_output: got %0d expected 0", got_pc.size()); else n_pass++;
        if_ready = 1'b1;
        for (int k = 0; k < 10; k++) step();
        n_checks++; if (got_pc.size() != 10) $display("FAIL release_count: got %0d expected 10", got_pc.size()); else n_pass++;
        for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
            n_checks++; if (got_pc[i] !== 32'(i * 4) || got_instr[i] !== (32'(i * 4) ^ c_xor))
                $display("FAIL release_order[%0d]: got pc=%h instr=%h expected %h %h", i, got_pc[i], got_instr[i], 32'(i * 4), 32'(i * 4) ^ c_xor);
            else n_pass++;
        end
    endtask

    task automatic test_branch_squash();
        logic [31:0] exp_pc [5];
        exp_pc = '{32'h0, 32'h4, 32'h100, 32'h104, 32'h108};
        do_reset();
        lat = 3;
        for (int k = 0; k < 6; k++) step();
        redirect_valid = 1'b1;  redirect_src = PC_BR;  redirect_target = 32'h0000_0100;
        step();
        n_checks++; if (s_valid !== 1'b0 || s_req_valid !== 1'b0)
            $display("FAIL br_redirect_cycle: got valid=%b req=%b expected 0 0", s_valid, s_req_valid);
        else n_pass++;
        redirect_valid = 1'b0;  redirect_src = PC_INC;
        step();
        n_checks++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100)
            $display("FAIL br_new_req: got req=%b addr=%h expected 1 00000100", s_req_valid, s_req_addr);
        else n_pass++;
        for (int k = 0; k < 7; k++) step();
        n_checks++; if (got_pc.size() != 5) $display("FAIL br_count: got %0d expected 5", got_pc.size()); else n_pass++;
        for (int i = 0; i < 5 && i < got_pc.size(); i++) begin
            n_checks++; if (got_pc[i] !== exp_pc[i] || got_instr[i] !== (exp_pc[i] ^ c_xor))
                $display("FAIL br_stream[%0d]: got pc=%h instr=%h expected %h %h", i, got_pc[i], got_instr[i], exp_pc[i], exp_pc[i] ^ c_xor);
            else n_pass++;
        end
    endtask

    task automatic test_jal_with_stale_resp();
        do_reset();
        step();
        step();
        redirect_valid = 1'b1;  redirect_src = PC_JAL;  redirect_target = 32'h0000_0200;
        step();
        n_checks++; if (s_valid !== 1'b0 || s_req_valid !== 1'b0)
            $display("FAIL jal_redirect_cycle: got valid=%b req=%b expected 0 0", s_valid, s_req_valid);
        else n_pass++;
        redirect_valid = 1'b0;  redirect_src = PC_INC;
        step();
        n_checks++; if (s_valid !== 1'b0 || s_req_addr !== 32'h200)
            $display("FAIL jal_next_req: got valid=%b addr=%h expected 0 00000200", s_valid, s_req_addr);
        else n_pass++;
        step();
        n_checks++; if (s_valid !== 1'b1 || s_pc !== 32'h200 || s_instr !== (32'h200 ^ c_xor))
            $display("FAIL jal_target_instr: got valid=%b pc=%h instr=%h expected 1 00000200 %h", s_valid, s_pc, s_instr, 32'h200 ^ c_xor);
        else n_pass++;
    endtask

    task automatic test_pc_wrap();
        rst = 1'b1;
        b_redirect_valid = 1'b0;  b_redirect_src = PC_INC;  b_redirect_target = 32'h0;
        b_rst = 1'b1;
        pend_b.delete();
        step();
        step();
        b_rst = 1'b0;
        step();
        n_checks++; if (s2_req_valid !== 1'b1 || s2_req_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_first_req: got req=%b addr=%h expected 1 fffffffc", s2_req_valid, s2_req_addr);
        else n_pass++;
        step();
        n_checks++; if (s2_valid !== 1'b1 || s2_pc !== 32'hFFFF_FFFC || s2_p4 !== 32'h0 || s2_instr !== 32'h5A5A_FFFC)
            $display("FAIL wrap_plus4: got valid=%b pc=%h p4=%h instr=%h expected 1 fffffffc 00000000 5a5afffc", s2_valid, s2_pc, s2_p4, s2_instr);
        else n_pass++;
        n_checks++; if (s2_req_addr !== 32'h0) $display("FAIL wrap_second_addr: got %h expected 00000000", s2_req_addr); else n_pass++;
        step();
        b_redirect_valid = 1'b1;  b_redirect_src = PC_BR;  b_redirect_target = 32'h0000_0102;
        step();
        n_checks++; if (s2_valid !== 1'b0) $display("FAIL wrap_redirect_valid: got %b expected 0", s2_valid); else n_pass++;
        b_redirect_valid = 1'b0;  b_redirect_src = PC_INC;
        step();
        n_checks++; if (s2_req_valid !== 1'b1 || s2_req_addr !== 32'h100)
            $display("FAIL wrap_align_addr: got req=%b addr=%h expected 1 00000100", s2_req_valid, s2_req_addr);
        else n_pass++;
        step();
        n_checks++; if (s2_valid !== 1'b1 || s2_pc !== 32'h100 || s2_instr !== (32'h100 ^ c_xor))
            $display("FAIL wrap_target_instr: got valid=%b pc=%h instr=%h expected 1 00000100 %h", s2_valid, s2_pc, s2_instr, 32'h100 ^ c_xor);
        else n_pass++;
        b_rst = 1'b1;
    endtask

    task automatic test_inc_and_random_latency();
        do_reset();
        step();
        step();
        step();
        redirect_valid = 1'b1;  redirect_src = PC_INC;  redirect_target = 32'h0000_0300;
        step();
        n_checks++; if (s_valid !== 1'b0 || s_req_valid !== 1'b0)
            $display("FAIL inc_hold_cycle: got valid=%b req=%b expected 0 0", s_valid, s_req_valid);
        else n_pass++;
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        n_checks++; if (got_pc.size() != 5) $display("FAIL inc_count: got %0d expected 5", got_pc.size()); else n_pass++;
        lat = 3;
        rand_mode = 1'b1;
        for (int k = 0; k < 60; k++) step();
        rand_mode = 1'b0;  imem_req_ready = 1'b1;  if_ready = 1'b1;
        for (int k = 0; k < 20; k++) step();
        n_checks++; if (got_pc.size() < 15) $display("FAIL rand_progress: got %0d expected >=15", got_pc.size()); else n_pass++;
        for (int i = 0; i < got_pc.size(); i++) begin
            n_checks++; if (got_pc[i] !== 32'(i * 4) || got_instr[i] !== (32'(i * 4) ^ c_xor))
                $display("FAIL rand_order[%0d]: got pc=%h instr=%h expected %h %h", i, got_pc[i], got_instr[i], 32'(i * 4), 32'(i * 4) ^ c_xor);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;  n_pass = 0;  cyc = 0;  lat = 1;  n_acc = 0;  rand_mode = 1'b0;
        rst = 1'b1;  imem_req_ready = 1'b1;  if_ready = 1'b1;
        redirect_valid = 1'b0;  redirect_src = PC_INC;  redirect_target = 32'h0;
        imem_resp_valid = 1'b0;  imem_resp_data = 32'h0;
        b_rst = 1'b1;  b_redirect_valid = 1'b0;  b_redirect_src = PC_INC;  b_redirect_target = 32'h0;
        b_resp_valid = 1'b0;  b_resp_data = 32'h0;

        test_reset();
        test_stream();
        test_backpressure();
        test_branch_squash();
        test_jal_with_stale_resp();
        test_pc_wrap();
        test_inc_and_random_latency();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
